ecu_traffic_node: RTL and testbench

- Parametrised successor to the single-node sample ECU used in the mesh testbench.
- Acts as a synthetic processing element on one mesh port.
- Generates periodic request packets to every other node in round-robin order, and echoes responses to incoming requests through a receive FIFO.
- Keeps per-node traffic counters and sticky error flags for end-of-test checking.

---
 rtl/ecu_pkg.sv | 51 +++++
 rtl/ecu_sync_fifo.sv | 60 ++++++
 rtl/ecu_traffic_node.sv | 218 +++++++++++++++++++++
 tb/tb_ecu_traffic_node.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecu_pkg.sv
// ============================================================================
// Module      : ecu_pkg
// Description : Shared flit field offsets, type/mode constants and helpers
//               for the ECU traffic node.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecu_pkg;

  localparam logic TYPE_REQ = 1'b0;
  localparam logic TYPE_RSP = 1'b1;

  localparam int MODE_GEN  = 0;
  localparam int MODE_ECHO = 1;
  localparam int MODE_BOTH = 2;

  localparam int SEQ_W = 16;

  // Flit layout from LSB: dest_x, dest_y, then payload {seq, src_y, src_x, type}.
  function automatic int off_dest_x();
    return 0;
  endfunction

  function automatic int off_dest_y(input int xs);
    return xs;
  endfunction

  function automatic int off_type(input int xs, input int ys);
    return xs + ys;
  endfunction

  function automatic int off_src_x(input int xs, input int ys);
    return xs + ys + 1;
  endfunction

  function automatic int off_src_y(input int xs, input int ys);
    return 2 * xs + ys + 1;
  endfunction

  function automatic int off_seq(input int xs, input int ys);
    return 2 * xs + 2 * ys + 1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecu_sync_fifo.sv
// ============================================================================
// Module      : ecu_sync_fifo
// Description : Synchronous FIFO with full/empty flags; a pop frees space for
//               a push in the same cycle. DEPTH must be a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign rdata     = r_mem[r_rd];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ecu_traffic_node.sv
// ============================================================================
// Module      : ecu_traffic_node
// Description : Synthetic mesh processing element: periodic round-robin
//               request generator, request echo via FIFO, traffic counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecu_traffic_node
  import ecu_pkg::*;
#(
  parameter int X           = 2,
  parameter int Y           = 2,
  parameter int data_width  = 129,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int xcord       = 0,
  parameter int ycord       = 0,
  parameter int MODE        = 2,
  parameter int PERIOD      = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic [total_width-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [15:0]            tx_req_cnt,
  output logic [15:0]            tx_rsp_cnt,
  output logic [15:0]            rx_req_cnt,
  output logic [15:0]            rx_rsp_cnt,
  output logic                   err_overflow,
  output logic                   err_misroute
);

  localparam int O_DX   = off_dest_x();
  localparam int O_DY   = off_dest_y(x_size);
  localparam int O_TYPE = off_type(x_size, y_size);
  localparam int O_SX   = off_src_x(x_size, y_size);
  localparam int O_SY   = off_src_y(x_size, y_size);
  localparam int O_SEQ  = off_seq(x_size, y_size);
  localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int CW     = x_size + y_size;

  // A single-node mesh has nobody to talk to, so the generator stays idle.
  localparam bit GEN_EN  = (MODE != MODE_ECHO) && (X * Y > 1);
  localparam bit ECHO_EN = (MODE != MODE_GEN);

  localparam logic [x_size-1:0] SELF_X = x_size'(xcord);
  localparam logic [y_size-1:0] SELF_Y = y_size'(ycord);

  // Next node in raster order ({y,x} packed), x fastest, wrapping at the mesh edge.
  function automatic logic [CW-1:0] step(input logic [CW-1:0] p);
    int nx;
    int ny;
    nx = int'(p[x_size-1:0]) + 1;
    ny = int'(p[CW-1:x_size]);
    if (nx >= X) begin
      nx = 0;
      ny = ny + 1;
      if (ny >= Y) ny = 0;
    end
    return {ny[y_size-1:0], nx[x_size-1:0]};
  endfunction

  localparam logic [CW-1:0] SELF    = {SELF_Y, SELF_X};
  localparam logic [CW-1:0] PTR_RST = step(SELF);

  logic [total_width-1:0] r_odata;
  logic                   r_ovalid;
  logic [PW-1:0]          r_pcnt;
  logic                   r_gen_pending;
  logic [SEQ_W-1:0]       r_seq;
  logic [CW-1:0]          r_ptr;
  logic [15:0]            r_tx_req;
  logic [15:0]            r_tx_rsp;
  logic [15:0]            r_rx_req;
  logic [15:0]            r_rx_rsp;
  logic                   r_err_ovf;
  logic                   r_err_mis;

  logic [total_width-1:0] w_req;
  logic [total_width-1:0] w_rsp;
  logic [total_width-1:0] w_fifo_q;
  logic [CW-1:0]          w_ptr_a;
  logic [CW-1:0]          w_ptr_nxt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_load;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_gen_take;
  logic                   w_overflow;
  logic                   w_misroute;
  logic                   w_rx_type;
  logic                   w_unused_rx;

  assign w_ptr_a   = step(r_ptr);
  assign w_ptr_nxt = (w_ptr_a == SELF) ? step(w_ptr_a) : w_ptr_a;

  always_comb begin
    w_req                      = '0;
    w_req[O_DX +: x_size]      = r_ptr[x_size-1:0];
    w_req[O_DY +: y_size]      = r_ptr[CW-1:x_size];
    w_req[O_TYPE]              = TYPE_REQ;
    w_req[O_SX +: x_size]      = SELF_X;
    w_req[O_SY +: y_size]      = SELF_Y;
    w_req[O_SEQ +: SEQ_W]      = r_seq;
  end

  // Response goes back to the requester carrying its sequence number.
  always_comb begin
    w_rsp                      = '0;
    w_rsp[O_DX +: x_size]      = i_data[O_SX +: x_size];
    w_rsp[O_DY +: y_size]      = i_data[O_SY +: y_size];
    w_rsp[O_TYPE]              = TYPE_RSP;
    w_rsp[O_SX +: x_size]      = SELF_X;
    w_rsp[O_SY +: y_size]      = SELF_Y;
    w_rsp[O_SEQ +: SEQ_W]      = i_data[O_SEQ +: SEQ_W];
  end

  assign w_rx_type   = i_data[O_TYPE];
  assign w_misroute  = i_valid && ((i_data[O_DX +: x_size] != SELF_X) ||
                                   (i_data[O_DY +: y_size] != SELF_Y));
  assign w_unused_rx = ^i_data;

  assign w_load     = ~r_ovalid | i_ready;
  assign w_pop      = w_load & ~w_empty;
  assign w_gen_take = w_load & w_empty & r_gen_pending;
  assign w_push     = i_valid && (w_rx_type == TYPE_REQ) && ECHO_EN;
  assign w_overflow = w_push & w_full & ~w_pop;

  ecu_sync_fifo #(
    .WIDTH (total_width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_rsp),
    .pop   (w_pop),
    .rdata (w_fifo_q),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_odata       <= '0;
      r_ovalid      <= 1'b0;
      r_pcnt        <= '0;
      r_gen_pending <= 1'b0;
      r_seq         <= '0;
      r_ptr         <= PTR_RST;
      r_tx_req      <= '0;
      r_tx_rsp      <= '0;
      r_rx_req      <= '0;
      r_rx_rsp      <= '0;
      r_err_ovf     <= 1'b0;
      r_err_mis     <= 1'b0;
    end else begin
      // Responses take priority over fresh requests.
      if (w_load) begin
        if (!w_empty) begin
          r_odata  <= w_fifo_q;
          r_ovalid <= 1'b1;
        end else if (r_gen_pending) begin
          r_odata  <= w_req;
          r_ovalid <= 1'b1;
        end else begin
          r_ovalid <= 1'b0;
        end
      end

      if (w_gen_take) begin
        r_gen_pending <= 1'b0;
        r_seq         <= r_seq + 16'd1;
        r_ptr         <= w_ptr_nxt;
      end else if (GEN_EN && enable && !r_gen_pending) begin
        if (r_pcnt == PW'(PERIOD - 1)) begin
          r_pcnt        <= '0;
          r_gen_pending <= 1'b1;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end

      if (r_ovalid && i_ready) begin
        if (r_odata[O_TYPE] == TYPE_REQ) r_tx_req <= sat_inc16(r_tx_req);
        else                             r_tx_rsp <= sat_inc16(r_tx_rsp);
      end

      if (i_valid) begin
        if (w_rx_type == TYPE_REQ) r_rx_req <= sat_inc16(r_rx_req);
        else                       r_rx_rsp <= sat_inc16(r_rx_rsp);
      end

      if (w_misroute) r_err_mis <= 1'b1;
      if (w_overflow) r_err_ovf <= 1'b1;
    end
  end

  assign o_data       = r_odata;
  assign o_valid      = r_ovalid;
  assign tx_req_cnt   = r_tx_req;
  assign tx_rsp_cnt   = r_tx_rsp;
  assign rx_req_cnt   = r_rx_req;
  assign rx_rsp_cnt   = r_rx_rsp;
  assign err_overflow = r_err_ovf;
  assign err_misroute = r_err_mis;

endmodule

`default_nettype wire

// File: tb/tb_ecu_traffic_node.sv
// ============================================================================
// Module      : tb_ecu_traffic_node
// Description : Scoreboard bench: a generator node (0,0) and an echo node (1,1).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ecu_traffic_node;

  localparam int TW = 131;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_g, en_g, iv_g, ir_g, ov_g, eo_g, em_g;
  logic [TW-1:0] id_g, od_g;
  logic [15:0]   txq_g, txs_g, rxq_g, rxs_g;
  logic          rst_e, en_e, iv_e, ir_e, ov_e, eo_e, em_e;
  logic [TW-1:0] id_e, od_e;
  logic [15:0]   txq_e, txs_e, rxq_e, rxs_e;

  int n_vec = 0;
  int n_err = 0;

  logic [TW-1:0] q_g[$];
  logic [TW-1:0] q_e[$];

  ecu_traffic_node #(.X(2), .Y(2), .data_width(129), .x_size(1), .y_size(1),
                     .xcord(0), .ycord(0), .MODE(0), .PERIOD(4), .FIFO_DEPTH(4)) dut_g (
    .clk(clk), .rst(rst_g), .enable(en_g), .i_data(id_g), .i_valid(iv_g),
    .o_data(od_g), .o_valid(ov_g), .i_ready(ir_g),
    .tx_req_cnt(txq_g), .tx_rsp_cnt(txs_g), .rx_req_cnt(rxq_g), .rx_rsp_cnt(rxs_g),
    .err_overflow(eo_g), .err_misroute(em_g));

  ecu_traffic_node #(.X(2), .Y(2), .data_width(129), .x_size(1), .y_size(1),
                     .xcord(1), .ycord(1), .MODE(1), .PERIOD(16), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst(rst_e), .enable(en_e), .i_data(id_e), .i_valid(iv_e),
    .o_data(od_e), .o_valid(ov_e), .i_ready(ir_e),
    .tx_req_cnt(txq_e), .tx_rsp_cnt(txs_e), .rx_req_cnt(rxq_e), .rx_rsp_cnt(rxs_e),
    .err_overflow(eo_e), .err_misroute(em_e));

  // Hand-written flit layout: [0]dx [1]dy [2]type [3]sx [4]sy [20:5]seq.
  function automatic logic [TW-1:0] mk(input int dx, input int dy, input int typ,
                                       input int sx, input int sy, input int seq);
    logic [TW-1:0] f;
    f        = '0;
    f[0]     = dx[0];
    f[1]     = dy[0];
    f[2]     = typ[0];
    f[3]     = sx[0];
    f[4]     = sy[0];
    f[20:5]  = seq[15:0];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_flit(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop on every accepted flit; stalled flits must stay put.
  logic          hold_g = 1'b0, hold_e = 1'b0;
  logic [TW-1:0] hd_g, hd_e;

  always @(negedge clk) begin
    if (rst_g) hold_g = 1'b0;
    else begin
      if (hold_g) cmp_flit("g_hold", ov_g ? od_g : '0, hd_g);
      if (ov_g && ir_g) begin
        if (q_g.size() == 0) cmp_flit("g_unexpected", od_g, '0);
        else cmp_flit("g_flit", od_g, q_g.pop_front());
      end
      hold_g = ov_g && !ir_g;
      hd_g   = od_g;
    end
  end

  always @(negedge clk) begin
    if (rst_e) hold_e = 1'b0;
    else begin
      if (hold_e) cmp_flit("e_hold", ov_e ? od_e : '0, hd_e);
      if (ov_e && ir_e) begin
        if (q_e.size() == 0) cmp_flit("e_unexpected", od_e, '0);
        else cmp_flit("e_flit", od_e, q_e.pop_front());
      end
      hold_e = ov_e && !ir_e;
      hd_e   = od_e;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_seen[4];
    int nseen;
    int cyc;
    t_seen = '{0, 0, 0, 0};
    rst_g = 1; rst_e = 1; en_g = 0; en_e = 1;
    iv_g = 0; ir_g = 1; id_g = '0;
    iv_e = 0; ir_e = 1; id_e = '0;
    tick(); tick();
    chk("rst_ovalid", 32'(ov_g), 0);
    chk("rst_odata", 32'(od_g != '0), 0);
    chk("rst_txreq", 32'(txq_g), 0);
    chk("rst_flags", 32'({eo_e, em_e, eo_g, em_g}), 0);
    rst_g = 0; rst_e = 0;
    tick();

    // Round-robin generation from (0,0): (1,0),(0,1),(1,1),(1,0).
    q_g.push_back(mk(1, 0, 0, 0, 0, 0));
    q_g.push_back(mk(0, 1, 0, 0, 0, 1));
    q_g.push_back(mk(1, 1, 0, 0, 0, 2));
    q_g.push_back(mk(1, 0, 0, 0, 0, 3));
    en_g = 1; cyc = 0; nseen = 0;
    for (int i = 0; i < 60 && nseen < 4; i++) begin
      tick(); cyc++;
      if (ov_g) begin t_seen[nseen] = cyc; nseen++; end
    end
    en_g = 0;
    chk("gen_count", 32'(nseen), 4);
    chk("gen_first_latency", 32'(t_seen[0]), 5);
    for (int i = 1; i < 4; i++) chk("gen_spacing", 32'(t_seen[i] - t_seen[i-1]), 5);
    tick(); tick();
    chk("gen_txreq4", 32'(txq_g), 4);
    chk("gen_queue_drained", 32'(q_g.size()), 0);

    // Generate-only node counts requests but never echoes.
    id_g = mk(0, 0, 0, 1, 1, 7); iv_g = 1;
    tick(); iv_g = 0;
    chk("g_rxreq", 32'(rxq_g), 1);
    chk("g_no_misroute", 32'(em_g), 0);
    tick(); tick(); tick();
    chk("g_no_echo", 32'(ov_g), 0);

    // Backpressure with a request pending.
    q_g.push_back(mk(0, 1, 0, 0, 0, 4));
    q_g.push_back(mk(1, 1, 0, 0, 0, 5));
    q_g.push_back(mk(1, 0, 0, 0, 0, 6));
    ir_g = 0; en_g = 1;
    for (int i = 0; i < 20 && !ov_g; i++) tick();
    chk("bp_valid", 32'(ov_g), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_txreq_frozen", 32'(txq_g), 4);
    ir_g = 1;
    for (int i = 0; i < 40 && txq_g != 16'd7; i++) tick();
    en_g = 0;
    tick(); tick(); tick();
    chk("bp_txreq7", 32'(txq_g), 7);
    chk("bp_queue_drained", 32'(q_g.size()), 0);

    // Reset while a flit is stalled.
    en_g = 1; ir_g = 0;
    for (int i = 0; i < 20 && !ov_g; i++) tick();
    chk("g_stalled_before_rst", 32'(ov_g), 1);
    rst_g = 1;
    tick();
    chk("g_rst_ovalid", 32'(ov_g), 0);
    chk("g_rst_odata", 32'(od_g != '0), 0);
    chk("g_rst_counts", 32'({txq_g, rxq_g}), 0);
    rst_g = 0; ir_g = 1;
    q_g.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20 && q_g.size() != 0; i++) tick();
    en_g = 0;
    chk("g_seq_restart", 32'(q_g.size()), 0);
    tick();
    chk("g_txreq_after_rst", 32'(txq_g), 1);

    // Echo latency: request at t, response valid at t+2.
    id_e = mk(1, 1, 0, 0, 0, 'hA5); iv_e = 1;
    q_e.push_back(mk(0, 0, 1, 1, 1, 'hA5));
    tick(); iv_e = 0;
    chk("echo_t1_idle", 32'(ov_e), 0);
    tick();
    chk("echo_t2_valid", 32'(ov_e), 1);
    tick();
    chk("echo_rxreq", 32'(rxq_e), 1);
    chk("echo_txrsp", 32'(txs_e), 1);

    // Fill output reg + FIFO, push/pop on full, then overflow.
    for (int k = 1; k <= 6; k++) q_e.push_back(mk(k % 2, (k / 2) % 2, 1, 1, 1, 'h100 + k));
    ir_e = 0;
    for (int k = 1; k <= 7; k++) begin
      id_e = mk(1, 1, 0, k % 2, (k / 2) % 2, 'h100 + k); iv_e = 1;
      ir_e = (k == 6);
      tick();
      if (k == 6) chk("full_pushpop_no_ovf", 32'(eo_e), 0);
    end
    iv_e = 0; ir_e = 0;
    chk("ovf_set", 32'(eo_e), 1);
    chk("ovf_rxreq", 32'(rxq_e), 8);
    tick(); tick(); tick();
    ir_e = 1;
    for (int i = 0; i < 30 && q_e.size() != 0; i++) tick();
    chk("ovf_queue_drained", 32'(q_e.size()), 0);
    tick();
    chk("ovf_txrsp", 32'(txs_e), 7);
    chk("ovf_idle_after", 32'(ov_e), 0);

    // Misrouted flit into (1,1).
    chk("mis_clear", 32'(em_e), 0);
    id_e = mk(0, 1, 1, 0, 0, 'h55); iv_e = 1;
    tick(); iv_e = 0;
    chk("mis_set", 32'(em_e), 1);
    chk("mis_rxrsp", 32'(rxs_e), 1);
    tick(); tick(); tick();
    chk("mis_sticky", 32'(em_e), 1);

    // Reset the echo node mid-transfer; FIFO contents must be discarded.
    ir_e = 0;
    id_e = mk(1, 1, 0, 0, 1, 'h21); iv_e = 1;
    tick();
    id_e = mk(1, 1, 0, 1, 0, 'h22);
    tick(); iv_e = 0;
    chk("e_stalled_before_rst", 32'(ov_e), 1);
    rst_e = 1;
    tick();
    chk("e_rst_ovalid", 32'(ov_e), 0);
    chk("e_rst_odata", 32'(od_e != '0), 0);
    chk("e_rst_flags", 32'({eo_e, em_e}), 0);
    chk("e_rst_counts", 32'({rxq_e, txs_e}), 0);
    rst_e = 0; ir_e = 1;
    tick(); tick(); tick(); tick();
    chk("e_fifo_empty_after_rst", 32'(ov_e), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
